// File: rtl/param_memory.sv
// Parametrised single-port data memory with per-lane write enables, selectable
// read latency and an optional post-reset clear sweep with busy/err reporting.
module param_memory #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int LANE_W         = 8,
    parameter int READ_LATENCY   = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/LANE_W-1:0]   we,
    input  logic                       re,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic                       busy,
    output logic                       err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NL    = DATA_W / LANE_W;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   ctr;
    logic                sweep_last;
    logic                access;
    logic [DATA_W-1:0]   mem [DEPTH];

    // The sweep ends on the edge that clears the last index; the counter
    // simply wraps back to zero afterwards and is unused until the next sweep.
    assign sweep_last = (ctr == '1);
    assign access     = (we != '0) || re;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
        else
            state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (state == S_CLEAR && sweep_last)
            state_next = S_READY;
    end

    always_comb begin
        busy = (state == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= '0;
            err <= 1'b0;
        end else if (busy) begin
            ctr <= ctr + ADDR_W'(1);
            if (access)
                err <= 1'b1;
        end
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM; zeroing
    // is done by the sweep one word per cycle instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (!rst)
                mem[ctr] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (we[i])
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata  = mem[addr];
            assign rvalid = re & ~busy;
        end else begin : g_reg_read
            // Read-first: the registered word is the one present before any
            // write landing on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= re & ~busy;
                    if (re && !busy)
                        rdata <= mem[addr];
                end
            end
        end
    endgenerate

endmodule
